// File: rtl/bus_pkg.sv
// Shared state encoding and region-decode rule for the bus_demux request router.
package bus_pkg;

    localparam int unsigned SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_e;

    // A region index selects a target only when it is below the populated target count.
    function automatic logic region_mapped(input logic [SEL_W-1:0] idx, input int unsigned n_tgt);
        return 32'(idx) < n_tgt;
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address-region decode: top SEL_W address bits pick one target.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int unsigned N_TGT  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [N_TGT-1:0]  sel,
    output logic              unmapped
);

    logic [SEL_W-1:0] idx;
    logic             unused_low;

    assign idx        = addr[ADDR_W-1 -: SEL_W];
    assign unused_low = ^addr[ADDR_W-SEL_W-1:0];

    always_comb begin
        sel      = '0;
        unmapped = !region_mapped(idx, N_TGT);
        for (int unsigned i = 0; i < N_TGT; i++) begin
            if (idx == SEL_W'(i)) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_demux.sv
// Single-outstanding request demultiplexer: routes one initiator to N_TGT targets
// by address region and returns the selected target's response.
module bus_demux
    import bus_pkg::*;
#(
    parameter int unsigned N_TGT   = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic                      req_we,
    input  logic [DATA_W/8-1:0]       req_be,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_err,
    output logic [N_TGT-1:0]          tgt_req_valid,
    input  logic [N_TGT-1:0]          tgt_req_ready,
    output logic [ADDR_W-1:0]         tgt_addr,
    output logic                      tgt_we,
    output logic [DATA_W/8-1:0]       tgt_be,
    output logic [DATA_W-1:0]         tgt_wdata,
    input  logic [N_TGT-1:0]          tgt_resp_valid,
    input  logic [N_TGT*DATA_W-1:0]   tgt_resp_rdata,
    input  logic [N_TGT-1:0]          tgt_resp_err
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state;
    logic [N_TGT-1:0]   cap_sel;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [N_TGT-1:0]   dec_sel;
    logic               dec_unmapped;
    logic               hit_ready;
    logic               hit_resp;
    logic               hit_err;
    logic               tmo_hit;
    logic [DATA_W-1:0]  hit_rdata;

    bus_addr_decode #(
        .N_TGT  (N_TGT),
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr     (req_addr),
        .sel      (dec_sel),
        .unmapped (dec_unmapped)
    );

    // Only the captured target's handshake and response reach the FSM.
    assign hit_ready = |(tgt_req_ready & cap_sel);
    assign hit_resp  = |(tgt_resp_valid & cap_sel);
    assign hit_err   = |(tgt_resp_err & cap_sel);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    always_comb begin
        hit_rdata = '0;
        for (int unsigned i = 0; i < N_TGT; i++) begin
            if (cap_sel[i]) begin
                hit_rdata = tgt_resp_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction FSM with registered outputs; completion wins over timeout in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            tgt_req_valid <= '0;
            tgt_addr      <= '0;
            tgt_we        <= 1'b0;
            tgt_be        <= '0;
            tgt_wdata     <= '0;
            cap_sel       <= '0;
            tmo_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        tgt_addr  <= req_addr;
                        tgt_we    <= req_we;
                        tgt_be    <= req_be;
                        tgt_wdata <= req_wdata;
                        cap_sel   <= dec_sel;
                        tmo_cnt   <= '0;
                        if (dec_unmapped) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state         <= REQ;
                            tgt_req_valid <= dec_sel;
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    if (hit_ready && hit_resp) begin
                        state         <= DONE;
                        tgt_req_valid <= '0;
                        resp_valid    <= 1'b1;
                        resp_err      <= hit_err;
                        resp_rdata    <= (tgt_we || hit_err) ? '0 : hit_rdata;
                    end else if (tmo_hit) begin
                        state         <= DONE;
                        tgt_req_valid <= '0;
                        resp_valid    <= 1'b1;
                        resp_err      <= 1'b1;
                        resp_rdata    <= '0;
                    end else if (hit_ready) begin
                        state         <= RESP;
                        tgt_req_valid <= '0;
                    end
                end
                RESP: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    if (hit_resp) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= hit_err;
                        resp_rdata <= (tgt_we || hit_err) ? '0 : hit_rdata;
                    end else if (tmo_hit) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
